// File: rtl/ir_nec_tx_pkg.sv
// Shared NEC definitions: unit counts for each frame element, TX FSM states and payload helpers.
package ir_nec_tx_pkg;

   localparam int LEAD_MARK_U  = 16;
   localparam int LEAD_SPACE_U = 8;
   localparam int RPT_SPACE_U  = 4;
   localparam int BIT_MARK_U   = 1;
   localparam int ZERO_SPACE_U = 1;
   localparam int ONE_SPACE_U  = 3;
   localparam int STOP_U       = 1;
   localparam int SLOT_U       = 192;
   localparam int NUM_BITS     = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD_MARK,
      ST_LEAD_SPACE,
      ST_BIT_MARK,
      ST_BIT_SPACE,
      ST_STOP_MARK,
      ST_GAP
   } tx_state_t;

   function automatic logic is_mark(tx_state_t s);
      return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
   endfunction

   // Transmitted LSB first, so bit 0 is addr[0].
   function automatic logic [31:0] nec_payload(logic [7:0] addr, logic [7:0] cmd);
      return {~cmd, cmd, ~addr, addr};
   endfunction

endpackage

// File: rtl/ir_nec_tx_carrier.sv
// Carrier generator: square wave gated by en, restarting high on every restart pulse.
module ir_carrier_gen #(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int CARRIER_FREQ = 38_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic carrier
);

   localparam int CAR_HALF = CLK_FREQ / (2 * CARRIER_FREQ);
   localparam int PW       = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;

   logic [PW-1:0] phase;

   // en/restart describe the coming cycle, so carrier lines up with the registered envelope.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         phase   <= '0;
         carrier <= 1'b0;
      end else if (restart) begin
         phase   <= '0;
         carrier <= 1'b1;
      end else if (phase == PW'(CAR_HALF - 1)) begin
         phase   <= '0;
         carrier <= ~carrier;
      end else begin
         phase <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: frame/repeat FSM, unit/bit/slot counters, payload shifter and LED drive.
module ir_nec_tx
   import ir_nec_tx_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int CARRIER_FREQ = 38_000,
   parameter int CARRIER_EN   = 1,
   parameter int OUT_INV      = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_addr,
   input  logic [7:0] tx_cmd,
   input  logic       tx_start,
   input  logic       tx_repeat,
   output logic       busy,
   output logic       done,
   output logic       ir_env,
   output logic       ir_out
);

   localparam int UNIT_CYC = CLK_FREQ * 9 / 16000;
   localparam int UW       = $clog2(UNIT_CYC);

   tx_state_t     state, state_nxt;
   logic [UW-1:0] unit_cnt;
   logic [4:0]    dur_cnt;
   logic [4:0]    dur_last;
   logic [7:0]    slot_cnt;
   logic [4:0]    bit_idx;
   logic [31:0]   shreg;
   logic          rpt;
   logic          unit_end, dur_end, slot_end;
   logic          carrier, drive;

   assign unit_end = (unit_cnt == UW'(UNIT_CYC - 1));
   assign dur_end  = unit_end && (dur_cnt == dur_last);
   assign slot_end = unit_end && (slot_cnt == 8'(SLOT_U - 1));

   always_comb begin
      dur_last = '0;
      case (state)
         ST_LEAD_MARK:  dur_last = 5'(LEAD_MARK_U - 1);
         ST_LEAD_SPACE: dur_last = rpt ? 5'(RPT_SPACE_U - 1) : 5'(LEAD_SPACE_U - 1);
         ST_BIT_MARK:   dur_last = 5'(BIT_MARK_U - 1);
         ST_BIT_SPACE:  dur_last = shreg[0] ? 5'(ONE_SPACE_U - 1) : 5'(ZERO_SPACE_U - 1);
         ST_STOP_MARK:  dur_last = 5'(STOP_U - 1);
         default:       dur_last = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:       if (tx_start || tx_repeat) state_nxt = ST_LEAD_MARK;
         ST_LEAD_MARK:  if (dur_end) state_nxt = ST_LEAD_SPACE;
         ST_LEAD_SPACE: if (dur_end) state_nxt = rpt ? ST_STOP_MARK : ST_BIT_MARK;
         ST_BIT_MARK:   if (dur_end) state_nxt = ST_BIT_SPACE;
         ST_BIT_SPACE:
            if (dur_end) state_nxt = (bit_idx == 5'(NUM_BITS - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
         ST_STOP_MARK:  if (dur_end) state_nxt = ST_GAP;
         ST_GAP:        if (slot_end) state_nxt = ST_IDLE;
         default:       state_nxt = ST_IDLE;
      endcase
   end

   // Every state lasts whole units and clears unit_cnt on entry, so unit_cnt stays
   // in phase with the slot from the first lead cycle and can also drive slot_cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         unit_cnt <= '0;
         dur_cnt  <= '0;
         slot_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rpt      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ir_env   <= 1'b0;
      end else begin
         if (state_nxt != state) begin
            unit_cnt <= '0;
            dur_cnt  <= '0;
         end else if (unit_end) begin
            unit_cnt <= '0;
            dur_cnt  <= dur_cnt + 1'b1;
         end else if (state != ST_IDLE) begin
            unit_cnt <= unit_cnt + 1'b1;
         end

         if (state == ST_IDLE)
            slot_cnt <= '0;
         else if (unit_end && slot_cnt != 8'(SLOT_U - 1))
            slot_cnt <= slot_cnt + 1'b1;

         if (state == ST_IDLE && state_nxt == ST_LEAD_MARK) begin
            shreg   <= nec_payload(tx_addr, tx_cmd);
            rpt     <= !tx_start;
            bit_idx <= '0;
         end else if (state == ST_BIT_SPACE && dur_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
         end

         busy   <= (state_nxt != ST_IDLE);
         done   <= (state == ST_GAP) && (state_nxt == ST_IDLE);
         ir_env <= is_mark(state_nxt);
      end
   end

   ir_carrier_gen #(
      .CLK_FREQ    (CLK_FREQ),
      .CARRIER_FREQ(CARRIER_FREQ)
   ) u_carrier (
      .clk    (clk),
      .rst    (rst),
      .en     (is_mark(state_nxt)),
      .restart(is_mark(state_nxt) && (state_nxt != state)),
      .carrier(carrier)
   );

   // Carrier is already gated by the envelope; only a constant inversion follows the flops.
   assign drive  = (CARRIER_EN != 0) ? carrier : ir_env;
   assign ir_out = drive ^ (OUT_INV != 0);

endmodule

// File: tb/tb_ir_nec_tx.sv
// Scoreboard bench for ir_nec_tx: expected mark/space runs and frame lengths queued by stimulus, checked by a monitor.
module tb_ir_nec_tx;

   // 80 kHz clock, 1.9 kHz carrier: unit = 80000*9/16000 = 45 cycles, half-period = 21 cycles.
   localparam int U    = 45;
   localparam int CH   = 21;
   localparam int SLOT = 192 * U;   // 8640

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_addr, tx_cmd;
   logic       tx_start, tx_repeat;
   logic       busy, done, ir_env, ir_out;

   always #5 clk = ~clk;

   ir_nec_tx #(
      .CLK_FREQ    (80_000),
      .CARRIER_FREQ(1_900),
      .CARRIER_EN  (1),
      .OUT_INV     (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_addr  (tx_addr),
      .tx_cmd   (tx_cmd),
      .tx_start (tx_start),
      .tx_repeat(tx_repeat),
      .busy     (busy),
      .done     (done),
      .ir_env   (ir_env),
      .ir_out   (ir_out)
   );

   typedef struct {
      bit mark;
      int len;
   } seg_t;

   seg_t seg_q[$];
   int   done_q[$];
   int   env_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_frame(logic [7:0] a, logic [7:0] c, bit r);
      logic [31:0] p;
      int          hi;
      p = {~c, c, ~a, a};
      seg_q.push_back('{mark: 1'b1, len: 16 * U});
      seg_q.push_back('{mark: 1'b0, len: r ? 4 * U : 8 * U});
      hi = 16 * U;
      if (!r) begin
         for (int i = 0; i < 32; i++) begin
            seg_q.push_back('{mark: 1'b1, len: U});
            seg_q.push_back('{mark: 1'b0, len: p[i] ? 3 * U : U});
            hi += U;
         end
      end
      seg_q.push_back('{mark: 1'b1, len: U});
      hi += U;
      done_q.push_back(SLOT);
      env_q.push_back(hi);
   endtask

   task automatic pulse(logic [7:0] a, logic [7:0] c, bit s, bit r);
      @(posedge clk); #1;
      tx_addr = a; tx_cmd = c; tx_start = s; tx_repeat = r;
      @(posedge clk); #1;
      tx_start = 1'b0; tx_repeat = 1'b0;
      tx_addr = 8'($urandom_range(0, 255));
      tx_cmd  = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_done(int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < limit);
      chk("done_seen", int'(done), 1);
   endtask

   // Monitor state
   int cyc = 0, seg_start = 0, frame_start = 0, hi_cnt = 0, cbad = 0, idle_bad = 0;
   bit prev_env = 0, prev_busy = 0, have_mark = 0, abort = 0, exp_out;
   seg_t e;

   task automatic take_seg(bit m, int len);
      chk(m ? "mark_pending" : "space_pending", int'(seg_q.size() > 0), 1);
      if (seg_q.size() > 0) begin
         e = seg_q.pop_front();
         chk("seg_kind", int'(m), int'(e.mark));
         chk(m ? "mark_len" : "space_len", len, e.len);
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            abort = 1'b1;
         end else if (abort) begin
            abort = 1'b0; have_mark = 1'b0; hi_cnt = 0; cbad = 0;
            prev_env = ir_env; prev_busy = busy;
         end else begin
            if (busy && !prev_busy) begin
               frame_start = cyc;
               hi_cnt = 0;
            end
            if (ir_env && !prev_env) begin
               if (have_mark) take_seg(1'b0, cyc - seg_start);
               seg_start = cyc;
               cbad = 0;
            end else if (!ir_env && prev_env) begin
               take_seg(1'b1, cyc - seg_start);
               chk("carrier_in_mark", cbad, 0);
               seg_start = cyc;
               have_mark = 1'b1;
            end
            if (ir_env) begin
               hi_cnt++;
               exp_out = (((cyc - seg_start) / CH) % 2 == 0) ? 1'b0 : 1'b1;
               if (ir_out !== exp_out) cbad++;
            end else if (ir_out !== 1'b1) begin
               idle_bad++;
            end
            if (done) begin
               chk("done_pending", int'(done_q.size() > 0), 1);
               chk("busy_at_done", int'(busy), 0);
               if (done_q.size() > 0) chk("frame_len", cyc - frame_start, done_q.pop_front());
               if (env_q.size() > 0) chk("env_high_total", hi_cnt, env_q.pop_front());
               have_mark = 1'b0;
            end
            prev_env = ir_env;
            prev_busy = busy;
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1; tx_addr = '0; tx_cmd = '0; tx_start = 1'b0; tx_repeat = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_env", int'(ir_env), 0);
      chk("reset_out", int'(ir_out), 1);

      // 1: full frame addr 0x00 cmd 0x45
      push_frame(8'h00, 8'h45, 1'b0);
      pulse(8'h00, 8'h45, 1'b1, 1'b0);
      chk("busy_after_accept", int'(busy), 1);
      wait_done(SLOT + 10);

      // 2: repeat code
      push_frame(8'h00, 8'h00, 1'b1);
      pulse(8'h12, 8'h34, 1'b0, 1'b1);
      wait_done(SLOT + 10);

      // 3: requests mid-frame and in the gap are ignored
      push_frame(8'h5A, 8'h3C, 1'b0);
      pulse(8'h5A, 8'h3C, 1'b1, 1'b0);
      repeat (40 * U) @(posedge clk);
      pulse(8'hFF, 8'hFF, 1'b1, 1'b0);
      repeat (110 * U) @(posedge clk);
      pulse(8'h01, 8'h02, 1'b1, 1'b1);
      chk("busy_in_gap", int'(busy), 1);
      wait_done(SLOT);

      // 4: start and repeat together -> full frame
      push_frame(8'hC3, 8'h81, 1'b0);
      pulse(8'hC3, 8'h81, 1'b1, 1'b1);
      wait_done(SLOT + 10);

      // 5: reset during bit 10 mark (lead 24U + bits 0..7 16U + bits 8,9 8U)
      push_frame(8'h00, 8'h00, 1'b0);
      pulse(8'h00, 8'h00, 1'b1, 1'b0);
      repeat (48 * U + 10) @(posedge clk);
      chk("env_before_abort", int'(ir_env), 1);
      @(posedge clk); #1 rst = 1'b1;
      seg_q.delete(); done_q.delete(); env_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_env", int'(ir_env), 0);
      chk("abort_out", int'(ir_out), 1);
      chk("abort_done", int'(done), 0);
      repeat (4 * U) @(posedge clk);
      chk("idle_after_abort", int'(busy), 0);

      push_frame(8'hA5, 8'h0F, 1'b0);
      pulse(8'hA5, 8'h0F, 1'b1, 1'b0);
      wait_done(SLOT + 10);

      repeat (5) @(negedge clk);
      chk("segs_left", seg_q.size(), 0);
      chk("dones_left", done_q.size(), 0);
      chk("idle_out_high", idle_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
